// File: rtl/mult_div_unit.sv
// +--------------------------------------------------------------------------+
// | mult_div_unit: iterative signed multiply/divide, one result bit per cycle |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             md_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] C_LAST = CW'(ITERS - 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               start_q;
  logic               op_q, sa_q, sb_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               w_accept, w_run, w_fix;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_mul_sum, w_div_sh;
  logic [WIDTH+1:0]   w_div_df;
  logic [2*WIDTH-1:0] w_acc_step, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem, w_res_hi, w_res_lo;

  assign div0 = md_sel & (b == '0);
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept) state_d = S_RUN;
      S_RUN:   if (cnt_q == C_LAST) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    w_accept = (state_q == S_IDLE) & start & ~start_q & ~div0;
    w_run    = (state_q == S_RUN);
    w_fix    = (state_q == S_FIX);
  end

  // Magnitudes: the most negative value maps to itself and is read as unsigned.
  assign w_a_mag = a[WIDTH-1] ? -a : a;
  assign w_b_mag = b[WIDTH-1] ? -b : b;

  // MULT keeps the multiplier in the low half and shifts right; DIV shifts the
  // dividend out of the low half and the quotient bits in behind it.
  always_comb begin
    w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    w_div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    w_div_df  = {1'b0, w_div_sh} - {2'b00, opnd_q};
    if (!op_q)
      w_acc_step = {w_mul_sum, acc_q[WIDTH-1:1]};
    else if (!w_div_df[WIDTH+1])
      w_acc_step = {w_div_df[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      w_acc_step = {w_div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    w_prod   = (sa_q ^ sb_q) ? -acc_q : acc_q;
    w_quo    = acc_q[WIDTH-1:0];
    w_rem    = acc_q[2*WIDTH-1:WIDTH];
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (op_q) begin
      w_res_lo = (sa_q ^ sb_q) ? -w_quo : w_quo;
      w_res_hi = sa_q ? -w_rem : w_rem;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      op_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      start_q <= start;
      done_q  <= w_fix;
      if (w_accept) begin
        op_q   <= md_sel;
        sa_q   <= a[WIDTH-1];
        sb_q   <= b[WIDTH-1];
        cnt_q  <= '0;
        opnd_q <= md_sel ? w_b_mag : w_a_mag;
        acc_q  <= {{WIDTH{1'b0}}, (md_sel ? w_a_mag : w_b_mag)};
      end else if (w_run) begin
        cnt_q <= cnt_q + 1'b1;
        acc_q <= w_acc_step;
      end
      if (w_fix) begin
        hi_q <= w_res_hi;
        lo_q <= w_res_lo;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// +--------------------------------------------------------------------------+
// | tb_mult_div_unit: scoreboard bench for mult_div_unit                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, md_sel;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        div0, busy, done;

  mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .md_sel(md_sel),
    .a(a), .b(b), .hi(hi), .lo(lo), .div0(div0), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t        scb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_hi = '0, cur_lo = '0;
  logic        prev_done = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain signed 64-bit arithmetic; SV division truncates toward
  // zero and the remainder takes the dividend's sign.
  function automatic logic [63:0] model(bit md, logic [31:0] av, logic [31:0] bv);
    longint sa, sbv, q, r;
    sa  = $signed(av);
    sbv = $signed(bv);
    if (!md) return sa * sbv;
    q = sa / sbv;
    r = sa % sbv;
    return {r[31:0], q[31:0]};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      cur_hi    = '0;
      cur_lo    = '0;
      prev_done = 1'b0;
    end else begin
      chk("done_pulse", {63'b0, done & prev_done}, 64'd0);
      if (done) begin
        if (scb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = scb.pop_front();
          chk("hi", {32'b0, hi}, {32'b0, e.hi});
          chk("lo", {32'b0, lo}, {32'b0, e.lo});
          chk("latency", 64'(cyc), 64'(e.due));
          cur_hi = e.hi;
          cur_lo = e.lo;
        end
      end else begin
        chk("hold_hi", {32'b0, hi}, {32'b0, cur_hi});
        chk("hold_lo", {32'b0, lo}, {32'b0, cur_lo});
      end
      prev_done = done;
    end
  end

  task automatic issue(bit md, logic [31:0] av, logic [31:0] bv, int hold, bit expect_acc);
    exp_t        e;
    logic [63:0] m;
    bit          z;
    @(negedge clk);
    md_sel = md;
    a      = av;
    b      = bv;
    start  = 1'b1;
    #1;
    z = md && (bv == 32'd0);
    chk("div0", {63'b0, div0}, {63'b0, z});
    if (expect_acc && !z) begin
      m     = model(md, av, bv);
      e.hi  = m[63:32];
      e.lo  = m[31:0];
      e.due = cyc + 34;
      scb.push_back(e);
    end
    repeat (hold) @(negedge clk);
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    md_sel = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((scb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {63'b0, n >= 200}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] av, bv;
    reset = 1'b1; start = 1'b0; md_sel = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi",   {32'b0, hi}, 64'd0);
    chk("rst_lo",   {32'b0, lo}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    reset = 1'b0;

    issue(0, 32'd7, 32'hFFFFFFFD, 1, 1);          wait_idle();
    issue(1, 32'hFFFFFFF9, 32'd2, 1, 1);          wait_idle();
    issue(1, 32'd7, 32'hFFFFFFFE, 1, 1);          wait_idle();
    chk("div_7_m2_lo", {32'b0, lo}, 64'hFFFFFFFD);
    chk("div_7_m2_hi", {32'b0, hi}, 64'h1);

    // Divide by zero: rejected, previous result stays.
    issue(1, 32'd5, 32'd0, 1, 1);
    chk("div0_busy", {63'b0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("div0_keep_hi", {32'b0, hi}, 64'h1);

    issue(0, 32'h80000000, 32'h80000000, 1, 1);  wait_idle();
    chk("min_sq_hi", {32'b0, hi}, 64'h40000000);
    issue(1, 32'h80000000, 32'hFFFFFFFF, 1, 1);  wait_idle();
    chk("min_div_lo", {32'b0, lo}, 64'h80000000);

    // Second edge while busy is ignored; long start gives one result.
    issue(0, 32'd5, 32'd6, 1, 1);
    repeat (8) @(negedge clk);
    issue(1, 32'd100, 32'd3, 1, 0);
    wait_idle();
    chk("ignored_lo", {32'b0, lo}, 64'd30);
    issue(0, 32'd9, 32'hFFFFFFF7, 60, 1);         wait_idle();
    repeat (45) @(negedge clk);

    // Reset mid-DIV discards the operation.
    issue(1, 32'd1000, 32'd7, 1, 1);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_hi",   {32'b0, hi}, 64'd0);
    chk("mid_rst_lo",   {32'b0, lo}, 64'd0);
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    scb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    issue(0, 32'd3, 32'd4, 1, 1);                 wait_idle();
    chk("post_rst_lo", {32'b0, lo}, 64'd12);

    for (int i = 0; i < 40; i++) begin
      av = $urandom;
      bv = $urandom;
      if ($urandom_range(0, 3) == 0) bv = 32'($urandom_range(0, 4)) - 32'd2;
      if ($urandom_range(0, 5) == 0) av = 32'h80000000;
      if ($urandom_range(0, 7) == 0) av = 32'($urandom_range(0, 20));
      issue(1'($urandom), av, bv, $urandom_range(1, 3), 1);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
